// File: rtl/affine_stream_pkg.sv
// Shared definitions for the affine stream engine: register map, status bit
// positions, control bit positions, FSM states and the default fixed-point split.
package affine_stream_pkg;

   localparam logic [7:0] REG_CTRL   = 8'h00;
   localparam logic [7:0] REG_STATUS = 8'h01;
   localparam logic [7:0] REG_COUNT  = 8'h02;
   localparam logic [7:0] REG_GAIN   = 8'h03;
   localparam logic [7:0] REG_OFFSET = 8'h04;
   localparam logic [7:0] REG_CYCLES = 8'h05;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;

   localparam int ST_BUSY   = 0;
   localparam int ST_DONE   = 1;
   localparam int ST_OVF    = 2;
   localparam int ST_WRDROP = 3;

   localparam int FRAC_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

endpackage

// File: rtl/dp_ram_sync.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// Contents are not reset; a read of an address written in the same cycle
// returns the old word.
module dp_ram_sync #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              wrEn_i,
   input  logic [ADDR_W-1:0] wrAddr_i,
   input  logic [DATA_W-1:0] wrData_i,
   input  logic [ADDR_W-1:0] rdAddr_i,
   output logic [DATA_W-1:0] rdData_o
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // Write port and registered read port share the single clock
   always_ff @(posedge clk_i) begin
      if (wrEn_i) begin
         mem[wrAddr_i] <= wrData_i;
      end
      rdData_o <= mem[rdAddr_i];
   end

endmodule

// File: rtl/affine_stream_engine.sv
// Affine stream engine: y[i] = sat((GAIN * x[i]) >>> FRAC + OFFSET) over the
// first N words of the input buffer, results placed in the output buffer.
// A three-stage pipeline (RAM read, multiply, shift/offset/saturate) feeds the
// output buffer write, so a run of N samples keeps the engine busy N+3 cycles.
module affine_stream_engine
   import affine_stream_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int FRAC   = FRAC_DEFAULT
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              data_in_write,
   input  logic [ADDR_W-1:0] data_in_address,
   input  logic [DATA_W-1:0] data_in_writedata,
   input  logic [7:0]        data_control_address,
   input  logic              data_control_read,
   input  logic              data_control_write,
   input  logic [DATA_W-1:0] data_control_writedata,
   output logic [DATA_W-1:0] data_control_readdata,
   input  logic [ADDR_W-1:0] data_out_address,
   output logic [DATA_W-1:0] data_out_readdata,
   input  logic [31:0]       gp_gp_out,
   output logic [31:0]       gp_gp_in
);

   localparam int CNT_W  = ADDR_W + 1;
   localparam int PROD_W = 2 * DATA_W;
   localparam logic [CNT_W-1:0]  DEPTH   = CNT_W'(2**ADDR_W);
   localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(2**ADDR_W);
   localparam logic signed [PROD_W-1:0] MAX_V = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] MIN_V = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   issueIdx_q, issueIdx_d;
   logic [CNT_W-1:0]   count_q;
   logic [DATA_W-1:0]  gain_q, offset_q, cycCnt_q, cycles_q, readdata_q;
   logic               done_q, ovf_q, wrDrop_q, gpPrev_q;
   logic               v1_q, v2_q, v3_q;
   logic [ADDR_W-1:0]  idx1_q, idx2_q, idx3_q;
   logic signed [PROD_W-1:0] prod_q;
   logic [DATA_W-1:0]  y_q;
   logic [DATA_W-1:0]  inRdData;

   logic               busy, ctrlWr, statusW1c, cfgWrEn;
   logic               abortReq, startReq, flush;
   logic               s0Valid, launch, finish, zeroStart;
   logic signed [PROD_W-1:0] gainExt, xExt, prodFull, shifted, offsetExt, sum;
   logic               satHi, satLo, clip;
   logic [DATA_W-1:0]  satVal, regMux;
   logic               unusedGpBits;

   assign busy      = (state_q != IDLE);
   assign ctrlWr    = data_control_write && (data_control_address == REG_CTRL);
   assign statusW1c = data_control_write && (data_control_address == REG_STATUS);
   assign cfgWrEn   = data_control_write && !busy;
   // An abort in the same CTRL write suppresses any start seen that cycle,
   // and the CTRL start bit and the GPIO edge merge into one request.
   assign abortReq  = ctrlWr && data_control_writedata[CTRL_ABORT];
   assign startReq  = ((ctrlWr && data_control_writedata[CTRL_START]) ||
                       (gp_gp_out[0] && !gpPrev_q)) && !abortReq;
   assign flush     = abortReq && busy;
   assign unusedGpBits = ^gp_gp_out[31:1];

   // FSM state and issue index registers
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q    <= IDLE;
         issueIdx_q <= '0;
      end else begin
         state_q    <= state_d;
         issueIdx_q <= issueIdx_d;
      end
   end

   // Next-state logic: issue one read per cycle in RUN, then drain the pipe
   always_comb begin
      state_d    = state_q;
      issueIdx_d = issueIdx_q;
      s0Valid    = 1'b0;
      launch     = 1'b0;
      finish     = 1'b0;
      zeroStart  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (startReq) begin
               if (count_q != '0) begin
                  state_d    = RUN;
                  issueIdx_d = '0;
                  launch     = 1'b1;
               end else begin
                  zeroStart  = 1'b1;
               end
            end
         end
         RUN: begin
            if (abortReq) begin
               state_d = IDLE;
            end else begin
               s0Valid = 1'b1;
               if (issueIdx_q == count_q - CNT_W'(1)) begin
                  state_d = DRAIN;
               end else begin
                  issueIdx_d = issueIdx_q + CNT_W'(1);
               end
            end
         end
         DRAIN: begin
            if (abortReq) begin
               state_d = IDLE;
            end else if (!v1_q && !v2_q) begin
               state_d = IDLE;
               finish  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign gainExt   = {{DATA_W{gain_q[DATA_W-1]}}, gain_q};
   assign xExt      = {{DATA_W{inRdData[DATA_W-1]}}, inRdData};
   assign prodFull  = gainExt * xExt;
   assign offsetExt = {{DATA_W{offset_q[DATA_W-1]}}, offset_q};
   assign shifted   = prod_q >>> FRAC;
   assign sum       = shifted + offsetExt;
   assign satHi     = (sum > MAX_V);
   assign satLo     = (sum < MIN_V);
   assign clip      = v2_q && (satHi || satLo);
   assign satVal    = satHi ? {1'b0, {(DATA_W-1){1'b1}}} :
                      satLo ? {1'b1, {(DATA_W-1){1'b0}}} : sum[DATA_W-1:0];

   // Pipeline valid bits, cleared together when a run is aborted
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else begin
         v1_q <= s0Valid && !flush;
         v2_q <= v1_q && !flush;
         v3_q <= v2_q && !flush;
      end
   end

   // Pipeline data: product, then saturated result, with the sample index alongside
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         idx1_q <= '0;
         idx2_q <= '0;
         idx3_q <= '0;
         prod_q <= '0;
         y_q    <= '0;
      end else begin
         idx1_q <= issueIdx_q[ADDR_W-1:0];
         idx2_q <= idx1_q;
         idx3_q <= idx2_q;
         prod_q <= prodFull;
         y_q    <= satVal;
      end
   end

   // Configuration registers, frozen while a run is in flight
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         count_q  <= '0;
         gain_q   <= '0;
         offset_q <= '0;
      end else if (cfgWrEn) begin
         if (data_control_address == REG_COUNT) begin
            count_q <= (data_control_writedata > DEPTH_W) ? DEPTH
                                                          : data_control_writedata[CNT_W-1:0];
         end
         if (data_control_address == REG_GAIN) begin
            gain_q <= data_control_writedata;
         end
         if (data_control_address == REG_OFFSET) begin
            offset_q <= data_control_writedata;
         end
      end
   end

   // Sticky status flags: hardware set beats a same-cycle write-one-to-clear
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wrDrop_q <= 1'b0;
         gpPrev_q <= 1'b0;
      end else begin
         gpPrev_q <= gp_gp_out[0];
         if (finish || zeroStart) begin
            done_q <= 1'b1;
         end else if (launch || (statusW1c && data_control_writedata[ST_DONE])) begin
            done_q <= 1'b0;
         end
         if (clip) begin
            ovf_q <= 1'b1;
         end else if (statusW1c && data_control_writedata[ST_OVF]) begin
            ovf_q <= 1'b0;
         end
         if (data_in_write && busy) begin
            wrDrop_q <= 1'b1;
         end else if (statusW1c && data_control_writedata[ST_WRDROP]) begin
            wrDrop_q <= 1'b0;
         end
      end
   end

   // Busy-cycle counter; CYCLES only takes its value when a run completes
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         cycCnt_q <= '0;
         cycles_q <= '0;
      end else begin
         if (launch || zeroStart) begin
            cycCnt_q <= '0;
         end else if (busy) begin
            cycCnt_q <= cycCnt_q + DATA_W'(1);
         end
         if (finish) begin
            cycles_q <= cycCnt_q + DATA_W'(1);
         end
      end
   end

   // Register read mux, built from pre-write register values
   always_comb begin
      regMux = '0;
      case (data_control_address)
         REG_STATUS: regMux = {{(DATA_W-4){1'b0}}, wrDrop_q, ovf_q, done_q, busy};
         REG_COUNT:  regMux = {{(DATA_W-CNT_W){1'b0}}, count_q};
         REG_GAIN:   regMux = gain_q;
         REG_OFFSET: regMux = offset_q;
         REG_CYCLES: regMux = cycles_q;
         default:    regMux = '0;
      endcase
   end

   // Registered read data, updated only on a read strobe
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         readdata_q <= '0;
      end else if (data_control_read) begin
         readdata_q <= regMux;
      end
   end

   assign data_control_readdata = readdata_q;
   assign gp_gp_in = {29'b0, ovf_q, done_q, busy};

   dp_ram_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) uInBuf (
      .clk_i    (clk_clk),
      .wrEn_i   (data_in_write && !busy),
      .wrAddr_i (data_in_address),
      .wrData_i (data_in_writedata),
      .rdAddr_i (issueIdx_q[ADDR_W-1:0]),
      .rdData_o (inRdData)
   );

   dp_ram_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) uOutBuf (
      .clk_i    (clk_clk),
      .wrEn_i   (v3_q),
      .wrAddr_i (idx3_q),
      .wrData_i (y_q),
      .rdAddr_i (data_out_address),
      .rdData_o (data_out_readdata)
   );

endmodule
